gate_truth_table_tester: RTL and testbench
==========================================

# gate_truth_table_tester

Stimulus-and-check engine for single-output, two-input logic gates (the lab's AND/OR/XOR primitives). On `start` it drives all four input combinations onto a device under test, waits a fixed settle time and samples the gate output through a synchronizer. It then compares the four captured bits against an expected truth table and reports pass/fail. It sits on the driving side of the gate's `A`/`B`/`out` interface, either on-chip as a self-test or wired to board pins and LEDs.

## Interface
- `SETTLE_CYCLES`, default 4: cycles each vector is held before sampling; must be ≥ 3 (elaboration-time check).
- `EXPECT`, default 4'b1000: expected truth table, bit index = {A,B}. The default is AND.
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  level-sensitive run request, sampled only in IDLE
- `dut_out`  in  1  gate output under test, asynchronous to the tester
- `drv_a`  out  1  gate input A
- `drv_b`  out  1  gate input B
- `busy`  out  1  high from the start edge until the done cycle inclusive
- `done`  out  1  one-cycle pulse at end of run
- `pass`  out  1  observed == EXPECT, valid from done until next start
- `observed`  out  4  captured output per vector, index {A,B}
- `fail_vec`  out  4  observed ^ EXPECT

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: drv_a/drv_b = 0 and busy = 0. If start = 1, then: idx ← 0, observed ← 0, pass ← 0, cnt ← 0, and go to SETTLE.
- SETTLE: {drv_a,drv_b} = idx. cnt increments. Leave to SAMPLE when cnt == SETTLE_CYCLES−1, so SETTLE lasts exactly SETTLE_CYCLES cycles.
- SAMPLE: observed[idx] ← synchronized dut_out. If idx == 3, go to DONE. Otherwise idx ← idx+1, cnt ← 0, and go to SETTLE.
- DONE: done = 1 and busy = 1 for one cycle. pass ← (observed == EXPECT). Go to IDLE.
- idx is 2 bits wide. The vector order is 00, 01, 10, 11. There is no wrap: the run terminates after idx 3.
- `fail_vec` is combinational from the observed register. It is meaningful only after done.
- start while busy: ignored. start held high: a new run begins the cycle after DONE, i.e. back-to-back runs with a single IDLE cycle.
- Reset asserted at any time: all registers clear immediately, the state goes to IDLE and no done pulse is issued. A partial observed result is discarded.
- Reset values: drv_a = drv_b = busy = done = pass = 0, observed = 0, fail_vec = EXPECT.

## Timing
- Let N = SETTLE_CYCLES. Vector k is driven from edge k(N+1)+1 through edge (k+1)(N+1), where edge 0 is the edge that samples start.
- dut_out passes through a 2-FF synchronizer. The value captured in SAMPLE reflects dut_out from ≥ N−2 cycles after the vector changed, which is why N ≥ 3 is required.
- done is high in the cycle following edge 4(N+1)+1. Total start-to-done latency is 4(N+1)+1 cycles; the default is 21.
- pass/observed/fail_vec are stable from the done cycle until the next accepted start.

## Structure
- Shared package `gate_test_pkg`:
  - state enum
  - truth-table constants `TT_AND = 4'b1000`, `TT_OR = 4'b1110`, `TT_XOR = 4'b0110`, `TT_NAND = 4'b0111`
  - vector-index width constant
- One sub-module: `sync_2ff`, a generic 1-bit two-flop synchronizer with async active-low reset to 0. It is reused for board switch inputs.
- Everything else lives in one FSM + counter module.

## Test plan
- Reset: hold rst_n = 0 with random start/dut_out → all outputs at reset values (fail_vec = 1000). Release → remains IDLE until start.
- Combinational AND model, N = 4: one-cycle start pulse → drv sequence 00,01,10,11, each held 5 cycles; done at cycle 21; observed = 1000, pass = 1, fail_vec = 0000.
- Stuck-at-1 DUT (dut_out = 1) → observed = 1111, pass = 0, fail_vec = 0111. Stuck-at-0 → observed = 0000, fail_vec = 1000.
- EXPECT = TT_XOR with XOR model → pass = 1. Same configuration with AND model → fail_vec = 1110, pass = 0.
- start pulsed during vector 1 → ignored, single done at cycle 21. start held high → second run begins one cycle after done and the second done lands at cycle 43.
- rst_n pulsed low during vector 2 → drv = 00, busy = 0 on the same cycle, no done. The next start gives a full, correct 21-cycle run.

Source files
------------

// File: rtl/gate_test_pkg.sv
// Shared definitions for the two-input gate truth-table tester.
// Holds the FSM state encoding, the vector-index width and the
// truth-table constants for the standard lab gates. Truth-table bit
// index is {A,B}.
package gate_test_pkg;

  localparam int unsigned IDX_W   = 2;
  localparam int unsigned NUM_VEC = 4;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VEC - 1);

  localparam logic [NUM_VEC-1:0] TT_AND  = 4'b1000;
  localparam logic [NUM_VEC-1:0] TT_OR   = 4'b1110;
  localparam logic [NUM_VEC-1:0] TT_XOR  = 4'b0110;
  localparam logic [NUM_VEC-1:0] TT_NAND = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer, async active-low reset to 0.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset
//   d     - asynchronous input
//   q     - synchronized output (two clk cycles of latency)
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // First stage may go metastable; second stage gives it a cycle to resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gate_truth_table_tester.sv
// Stimulus-and-check engine for a two-input, single-output logic gate.
// On start it drives {A,B} = 00,01,10,11, holds each vector for
// SETTLE_CYCLES cycles plus one sample cycle, captures the synchronized
// gate output per vector and compares the result against EXPECT.
// Ports:
//   clk      - system clock
//   rst_n    - asynchronous active-low reset
//   start    - run request, sampled only when idle
//   dut_out  - gate output under test (asynchronous)
//   drv_a    - gate input A
//   drv_b    - gate input B
//   busy     - high from the accepted start through the done cycle
//   done     - one-cycle end-of-run pulse
//   pass     - observed == EXPECT, valid from done until the next start
//   observed - captured gate output per vector, index {A,B}
//   fail_vec - observed ^ EXPECT
module gate_truth_table_tester
  import gate_test_pkg::*;
#(
  parameter int unsigned         SETTLE_CYCLES = 4,
  parameter logic [NUM_VEC-1:0]  EXPECT        = TT_AND
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               dut_out,
  output logic               drv_a,
  output logic               drv_b,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [NUM_VEC-1:0] observed,
  output logic [NUM_VEC-1:0] fail_vec
);

  // The synchronizer eats two cycles of the settle window; fewer than
  // three settle cycles would sample before the gate output is seen.
  if (SETTLE_CYCLES < 3) begin : g_settle_check
    $error("gate_truth_table_tester: SETTLE_CYCLES must be >= 3");
  end

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t               state, state_nx;
  logic [IDX_W-1:0]     idx, idx_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic [NUM_VEC-1:0]   observed_nx;
  logic                 pass_nx;
  logic                 drv_a_nx, drv_b_nx;
  logic                 busy_nx, done_nx;
  logic                 dut_out_sync;

  // Bring the asynchronous gate output into the clk domain.
  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dut_out),
    .q     (dut_out_sync)
  );

  // State register plus the registered datapath and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      idx      <= '0;
      cnt      <= '0;
      observed <= '0;
      pass     <= 1'b0;
      drv_a    <= 1'b0;
      drv_b    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      cnt      <= cnt_nx;
      observed <= observed_nx;
      pass     <= pass_nx;
      drv_a    <= drv_a_nx;
      drv_b    <= drv_b_nx;
      busy     <= busy_nx;
      done     <= done_nx;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    cnt_nx      = cnt;
    observed_nx = observed;
    pass_nx     = pass;
    drv_a_nx    = 1'b0;
    drv_b_nx    = 1'b0;
    busy_nx     = 1'b0;
    done_nx     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          idx_nx      = '0;
          cnt_nx      = '0;
          observed_nx = '0;
          pass_nx     = 1'b0;
          state_nx    = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cnt_nx = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          state_nx = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        observed_nx[idx] = dut_out_sync;
        if (idx == IDX_LAST) begin
          state_nx = ST_DONE;
        end else begin
          idx_nx   = idx + IDX_W'(1);
          cnt_nx   = '0;
          state_nx = ST_SETTLE;
        end
      end
      ST_DONE: begin
        pass_nx  = (observed == EXPECT);
        done_nx  = 1'b1;
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    // The driven vector lags the state by one register, so it stays on
    // the pins through the sample edge of its own vector.
    if (state == ST_SETTLE || state == ST_SAMPLE) begin
      {drv_a_nx, drv_b_nx} = idx;
    end

    // DONE term keeps busy asserted in the done-pulse cycle.
    busy_nx = (state_nx != ST_IDLE) || (state == ST_DONE);
  end

  assign fail_vec = observed ^ EXPECT;

endmodule

// File: tb/tb_gate_truth_table_tester.sv
module tb_gate_truth_table_tester;
  import gate_test_pkg::*;

  localparam int N   = 4;
  localparam int LAT = 4 * (N + 1) + 1;

  typedef struct {
    logic [3:0] tt;
    logic [3:0] obs;
    logic       pa;
    logic [3:0] fa;
    logic       px;
    logic [3:0] fx;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] gate_tt;

  logic       a_dut_out, a_drv_a, a_drv_b, a_busy, a_done, a_pass;
  logic [3:0] a_obs, a_fv;
  logic       x_dut_out, x_drv_a, x_drv_b, x_busy, x_done, x_pass;
  logic [3:0] x_obs, x_fv;

  int checks = 0;
  int errors = 0;

  // Gate models: each tester drives its own copy of the gate.
  assign a_dut_out = gate_tt[{a_drv_a, a_drv_b}];
  assign x_dut_out = gate_tt[{x_drv_a, x_drv_b}];

  gate_truth_table_tester #(.SETTLE_CYCLES(N), .EXPECT(TT_AND)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_out(a_dut_out),
    .drv_a(a_drv_a), .drv_b(a_drv_b), .busy(a_busy), .done(a_done),
    .pass(a_pass), .observed(a_obs), .fail_vec(a_fv)
  );

  gate_truth_table_tester #(.SETTLE_CYCLES(N), .EXPECT(TT_XOR)) dut_x (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_out(x_dut_out),
    .drv_a(x_drv_a), .drv_b(x_drv_b), .busy(x_busy), .done(x_done),
    .pass(x_pass), .observed(x_obs), .fail_vec(x_fv)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: gate output for every {A,B}, then compare with expectation.
  function automatic logic [3:0] model_obs(input logic [3:0] tt);
    logic [3:0] r;
    for (int v = 0; v < 4; v++) begin
      int a = v / 2;
      int b = v % 2;
      r[v] = tt[a * 2 + b];
    end
    return r;
  endfunction

  // One run from a single-cycle start pulse; trace and results checked.
  task automatic do_run(input string tag, input vec_t e, input bit mid_start);
    int bad_drv = -1;
    int bad_busy = -1;
    int done_a = -1;
    int done_x = -1;
    int n_done = 0;
    int exp_drv;
    gate_tt = e.tt;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c <= LAT + 3; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      if (mid_start && c == N + 3) start = 1'b1;
      if (mid_start && c == N + 4) start = 1'b0;
      exp_drv = (c >= 1 && c <= 4 * (N + 1)) ? (c - 1) / (N + 1) : 0;
      if (bad_drv < 0 && (int'({a_drv_a, a_drv_b}) != exp_drv ||
                          int'({x_drv_a, x_drv_b}) != exp_drv)) bad_drv = c;
      if (bad_busy < 0 && (a_busy != (c <= LAT) || x_busy != (c <= LAT))) bad_busy = c;
      if (a_done) begin n_done++; if (done_a < 0) done_a = c; end
      if (x_done) begin n_done++; if (done_x < 0) done_x = c; end
      if (c == LAT) begin
        check({tag, " a.observed"}, int'(a_obs), int'(e.obs));
        check({tag, " a.pass"},     int'(a_pass), int'(e.pa));
        check({tag, " a.fail_vec"}, int'(a_fv), int'(e.fa));
        check({tag, " x.observed"}, int'(x_obs), int'(e.obs));
        check({tag, " x.pass"},     int'(x_pass), int'(e.px));
        check({tag, " x.fail_vec"}, int'(x_fv), int'(e.fx));
      end
      if (c == LAT + 3) begin
        check({tag, " results held"}, int'({a_obs, a_pass, x_obs, x_pass}),
              int'({e.obs, e.pa, e.obs, e.px}));
      end
    end
    check({tag, " drv trace first bad cycle"}, bad_drv, -1);
    check({tag, " busy first bad cycle"}, bad_busy, -1);
    check({tag, " a.done cycle"}, done_a, LAT);
    check({tag, " x.done cycle"}, done_x, LAT);
    check({tag, " done pulses"}, n_done, 2);
  endtask

  vec_t tbl[6];
  vec_t rv;

  initial begin
    int bad;
    int done_cycles[$];
    tbl[0] = '{TT_AND,  4'b1000, 1'b1, 4'b0000, 1'b0, 4'b1110};
    tbl[1] = '{TT_OR,   4'b1110, 1'b0, 4'b0110, 1'b0, 4'b1000};
    tbl[2] = '{TT_XOR,  4'b0110, 1'b0, 4'b1110, 1'b1, 4'b0000};
    tbl[3] = '{TT_NAND, 4'b0111, 1'b0, 4'b1111, 1'b0, 4'b0001};
    tbl[4] = '{4'b1111, 4'b1111, 1'b0, 4'b0111, 1'b0, 4'b1001};
    tbl[5] = '{4'b0000, 4'b0000, 1'b0, 4'b1000, 1'b0, 4'b0110};

    // Reset with random activity on the inputs.
    rst_n = 1'b0;
    start = 1'b0;
    gate_tt = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      gate_tt = 4'($urandom_range(0, 15));
      check($sformatf("reset a.outputs %0d", i),
            int'({a_drv_a, a_drv_b, a_busy, a_done, a_pass, a_obs, a_fv}),
            int'({5'b00000, 4'b0000, 4'b1000}));
      check($sformatf("reset x.fail_vec %0d", i), int'(x_fv), int'(4'b0110));
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (a_busy || a_done || a_drv_a || a_drv_b || x_busy || x_done) bad++;
    end
    check("idle after reset activity", bad, 0);

    // Table-driven gate vectors.
    for (int i = 0; i < 6; i++) do_run($sformatf("tbl%0d", i), tbl[i], 1'b0);

    // start pulsed during vector 1 is ignored.
    do_run("mid_start", tbl[0], 1'b1);

    // start held high: back-to-back runs, dones at LAT and 2*LAT+1.
    gate_tt = TT_XOR;
    @(negedge clk);
    start = 1'b1;
    bad = -1;
    for (int c = 0; c <= 2 * LAT + 4; c++) begin
      @(negedge clk);
      if (c == LAT + 1) start = 1'b0;
      if (a_done) done_cycles.push_back(c);
      if (bad < 0 && a_busy != (c <= 2 * LAT + 1)) bad = c;
      if (c == LAT) check("hold run1 x.pass", int'(x_pass), 1);
      if (c == 2 * LAT + 1) begin
        check("hold run2 a.fail_vec", int'(a_fv), int'(4'b1110));
        check("hold run2 x.pass", int'(x_pass), 1);
      end
    end
    check("hold done count", done_cycles.size(), 2);
    if (done_cycles.size() == 2) begin
      check("hold done1 cycle", done_cycles[0], LAT);
      check("hold done2 cycle", done_cycles[1], 2 * LAT + 1);
    end
    check("hold busy first bad cycle", bad, -1);

    // Reset during vector 2 discards the partial result.
    gate_tt = TT_OR;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2 * N + 4) @(negedge clk);
    check("pre-reset drv", int'({a_drv_a, a_drv_b}), 2);
    check("pre-reset partial observed", int'(a_obs), int'(4'b0010));
    #2 rst_n = 1'b0;
    #1;
    check("async reset drv/busy/done", int'({a_drv_a, a_drv_b, a_busy, a_done}), 0);
    check("async reset observed", int'(a_obs), 0);
    check("async reset fail_vec", int'(a_fv), int'(4'b1000));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < LAT + 5; i++) begin
      @(negedge clk);
      if (a_done || a_busy || x_done || x_busy) bad++;
    end
    check("no done after reset", bad, 0);
    do_run("post_reset", tbl[1], 1'b0);

    // Random truth tables checked against the model.
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rv.tt  = 4'($urandom_range(0, 15));
      rv.obs = model_obs(rv.tt);
      rv.pa  = (rv.obs == TT_AND);
      rv.fa  = rv.obs ^ TT_AND;
      rv.px  = (rv.obs == TT_XOR);
      rv.fx  = rv.obs ^ TT_XOR;
      do_run($sformatf("rand%0d tt=%b", i, rv.tt), rv, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
